// File: rtl/alu_ctrl_md_pkg.sv
// Shared encodings for the MIPS ALU control and HI/LO multiply/divide sequencer.
// Holds the alu_sel, alu_class, wb_sel and funct codes, the sequencer state enum and the operation descriptor.
// Imported by the interface-level top and the iterative datapath core.
package alu_ctrl_md_pkg;

  // ALU select codes driven to the single-cycle datapath
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;
  localparam logic [3:0] ALU_ILL = 4'b1111;

  // ALU class from the main control unit
  localparam logic [1:0] CLS_ADD   = 2'b00;
  localparam logic [1:0] CLS_SUB   = 2'b01;
  localparam logic [1:0] CLS_RTYPE = 2'b10;
  localparam logic [1:0] CLS_RSVD  = 2'b11;

  // Writeback mux select
  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_HI  = 2'b01;
  localparam logic [1:0] WB_LO  = 2'b10;

  // R-type funct codes
  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_ADDU  = 6'b100001;
  localparam logic [5:0] F_SUB   = 6'b100010;
  localparam logic [5:0] F_SUBU  = 6'b100011;
  localparam logic [5:0] F_AND   = 6'b100100;
  localparam logic [5:0] F_OR    = 6'b100101;
  localparam logic [5:0] F_NOR   = 6'b100111;
  localparam logic [5:0] F_SLT   = 6'b101010;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  // Multiply/divide descriptor: funct[1] selects divide, funct[0] selects unsigned
  typedef struct packed {
    logic is_div;
    logic is_signed;
  } md_op_t;

endpackage

// File: rtl/alu_ctrl_md_if.sv
// Decode/sequencer bus between pipeline control and alu_ctrl_md.
// Master drives the decoded instruction and operands; slave returns selects, stall and HI/LO.
// XLEN must match the parameter of the alu_ctrl_md instance it is bound to.
interface alu_ctrl_md_if #(
  parameter int XLEN = 32
);
  logic            valid_in;
  logic [1:0]      alu_class;
  logic [5:0]      funct;
  logic [XLEN-1:0] rs_val;
  logic [XLEN-1:0] rt_val;
  logic [3:0]      alu_sel;
  logic [1:0]      wb_sel;
  logic            illegal;
  logic            busy;
  logic            stall;
  logic [XLEN-1:0] hi_out;
  logic [XLEN-1:0] lo_out;
  logic            md_done;

  modport master (
    output valid_in, alu_class, funct, rs_val, rt_val,
    input  alu_sel, wb_sel, illegal, busy, stall, hi_out, lo_out, md_done
  );

  modport slave (
    input  valid_in, alu_class, funct, rs_val, rt_val,
    output alu_sel, wb_sel, illegal, busy, stall, hi_out, lo_out, md_done
  );
endinterface

// File: rtl/alu_ctrl_md_iter_core.sv
// Iterative radix-2 multiply (shift-add) / divide (restoring) on operand magnitudes with sign fix-up.
// Latency: start at edge 0, XLEN RUN steps, done high during FIN (after edge XLEN), results valid with done.
// start is only honoured in IDLE; the caller must hold requests while busy.
module alu_ctrl_md_iter_core
  import alu_ctrl_md_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  md_op_t          op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] res_hi,
  output logic [XLEN-1:0] res_lo
);
  localparam int CNT_W = $clog2(XLEN) + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(XLEN - 1);

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  // r: product upper half / partial remainder; q: multiplier -> product lower half / dividend -> quotient
  logic [XLEN-1:0]   r, q, d;
  logic              is_div, neg_lo, neg_hi, div_zero;

  logic              a_neg, b_neg;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic [XLEN:0]     mul_sum, div_shift, div_diff;
  logic              div_ge;
  logic [2*XLEN-1:0] prod;

  // Operand magnitudes and sign flags at acceptance; unsigned ops never see a sign
  always_comb begin
    a_neg = op.is_signed & a[XLEN-1];
    b_neg = op.is_signed & b[XLEN-1];
    a_mag = a_neg ? -a : a;
    b_mag = b_neg ? -b : b;
  end

  // One radix-2 step: conditional add for multiply, trial subtract for divide
  always_comb begin
    mul_sum   = {1'b0, r} + (q[0] ? {1'b0, d} : '0);
    div_shift = {r, q[XLEN-1]};
    div_diff  = div_shift - {1'b0, d};
    div_ge    = div_shift >= {1'b0, d};
  end

  // Sign correction of the finished magnitudes; divide-by-zero forces an all-ones quotient
  always_comb begin
    prod = {r, q};
    if (neg_lo) prod = -prod;
    res_hi = prod[2*XLEN-1:XLEN];
    res_lo = prod[XLEN-1:0];
    if (is_div) begin
      res_hi = neg_hi ? -r : r;
      res_lo = div_zero ? '1 : (neg_lo ? -q : q);
    end
  end

  // Sequencer FSM with registered busy/done
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      r        <= '0;
      q        <= '0;
      d        <= '0;
      is_div   <= 1'b0;
      neg_lo   <= 1'b0;
      neg_hi   <= 1'b0;
      div_zero <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            r        <= '0;
            q        <= a_mag;
            d        <= b_mag;
            is_div   <= op.is_div;
            neg_lo   <= a_neg ^ b_neg;
            neg_hi   <= op.is_div & a_neg;
            div_zero <= op.is_div & (b == '0);
            cnt      <= '0;
            busy     <= 1'b1;
            state    <= RUN;
          end
        end
        RUN: begin
          if (is_div) begin
            r <= div_ge ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
            q <= {q[XLEN-2:0], div_ge};
          end else begin
            r <= mul_sum[XLEN:1];
            q <= {mul_sum[0], q[XLEN-1:1]};
          end
          cnt <= cnt + CNT_W'(1);
          if (cnt == LAST) begin
            state <= FIN;
            done  <= 1'b1;
          end
        end
        FIN: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/alu_ctrl_md.sv
// MIPS ALU control: combinational funct decode plus HI/LO registers fed by the iterative MD core.
// Decode is zero-latency; MULT/DIV results land in HI/LO XLEN+1 edges after acceptance.
// HI/LO-class instructions stall while the sequencer is busy; all other instructions never stall.
module alu_ctrl_md
  import alu_ctrl_md_pkg::*;
#(
  parameter int XLEN = 32
) (
  input logic          clk,
  input logic          rst_n,
  alu_ctrl_md_if.slave bus
);
  logic [3:0]      sel;
  logic [1:0]      wb;
  logic            known, md_fn, hilo_fn, mthi, mtlo;
  logic            md_op, md_start, mthi_wr, mtlo_wr;
  md_op_t          md_desc;
  logic            core_busy, core_done;
  logic [XLEN-1:0] res_hi, res_lo;
  logic [XLEN-1:0] hi_q, lo_q;

  // Instruction decode, independent of sequencer state
  always_comb begin
    sel     = ALU_ILL;
    wb      = WB_ALU;
    known   = 1'b0;
    md_fn   = 1'b0;
    hilo_fn = 1'b0;
    mthi    = 1'b0;
    mtlo    = 1'b0;
    case (bus.alu_class)
      CLS_ADD: begin sel = ALU_ADD; known = 1'b1; end
      CLS_SUB: begin sel = ALU_SUB; known = 1'b1; end
      CLS_RTYPE: begin
        known = 1'b1;
        case (bus.funct)
          F_ADD, F_ADDU: sel = ALU_ADD;
          F_SUB, F_SUBU: sel = ALU_SUB;
          F_AND:         sel = ALU_AND;
          F_OR:          sel = ALU_OR;
          F_NOR:         sel = ALU_NOR;
          F_SLT:         sel = ALU_SLT;
          F_MFHI: begin sel = ALU_ADD; wb = WB_HI; hilo_fn = 1'b1; end
          F_MFLO: begin sel = ALU_ADD; wb = WB_LO; hilo_fn = 1'b1; end
          F_MTHI: begin sel = ALU_ADD; mthi = 1'b1; hilo_fn = 1'b1; end
          F_MTLO: begin sel = ALU_ADD; mtlo = 1'b1; hilo_fn = 1'b1; end
          F_MULT, F_MULTU, F_DIV, F_DIVU: begin sel = ALU_ADD; md_fn = 1'b1; end
          default: known = 1'b0;
        endcase
      end
      CLS_RSVD: sel = ALU_ILL;
      default:  sel = ALU_ILL;
    endcase
  end

  // Acceptance: MD and MT operations only take effect while the sequencer is idle
  always_comb begin
    md_op          = bus.valid_in & (md_fn | hilo_fn);
    md_start       = bus.valid_in & md_fn & ~core_busy;
    mthi_wr        = bus.valid_in & mthi & ~core_busy;
    mtlo_wr        = bus.valid_in & mtlo & ~core_busy;
    md_desc.is_div    = bus.funct[1];
    md_desc.is_signed = ~bus.funct[0];
  end

  alu_ctrl_md_iter_core #(
    .XLEN(XLEN)
  ) u_core (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (md_start),
    .op     (md_desc),
    .a      (bus.rs_val),
    .b      (bus.rt_val),
    .busy   (core_busy),
    .done   (core_done),
    .res_hi (res_hi),
    .res_lo (res_lo)
  );

  // HI/LO: sequencer result wins; MTHI/MTLO can never coincide with it since they wait for idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (core_done) begin
      hi_q <= res_hi;
      lo_q <= res_lo;
    end else begin
      if (mthi_wr) hi_q <= bus.rs_val;
      if (mtlo_wr) lo_q <= bus.rs_val;
    end
  end

  assign bus.alu_sel = sel;
  assign bus.wb_sel  = wb;
  assign bus.illegal = bus.valid_in & ~known;
  assign bus.busy    = core_busy;
  assign bus.stall   = core_busy & md_op;
  assign bus.md_done = core_done;
  assign bus.hi_out  = hi_q;
  assign bus.lo_out  = lo_q;

endmodule

// File: tb/tb_alu_ctrl_md.sv
// Bench for alu_ctrl_md: directed vectors, a transaction-level HI/LO model and an every-cycle compare.
// The model computes results with plain integer arithmetic and tracks only a busy countdown.
// Literal expectations pin both the model and the DUT.
module tb_alu_ctrl_md;
  localparam int XLEN = 32;
  localparam logic [5:0] MULT = 6'h18, MULTU = 6'h19, DIV = 6'h1A, DIVU = 6'h1B;
  localparam logic [5:0] MFHI = 6'h10, MTHI = 6'h11, MFLO = 6'h12;

  logic clk = 1'b0;
  logic rst_n;
  int   n_assert = 0;
  int   n_fail = 0;

  alu_ctrl_md_if #(.XLEN(XLEN)) bus ();
  alu_ctrl_md #(.XLEN(XLEN)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // {hi, lo} an architectural MIPS machine would produce
  function automatic logic [63:0] md_model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    longint sp;
    longint unsigned up;
    sa = a;
    sb = b;
    case (f)
      MULT: begin sp = longint'(sa) * longint'(sb); return sp; end
      MULTU: begin up = {32'b0, a} * {32'b0, b}; return up; end
      DIVU: if (b == 0) return {a, 32'hFFFF_FFFF}; else return {a % b, a / b};
      default: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        else return {32'(sa % sb), 32'(sa / sb)};
      end
    endcase
  endfunction

  // {illegal, wb_sel, alu_sel} from the instruction table
  function automatic logic [6:0] dec_model(input logic v, input logic [1:0] c, input logic [5:0] f);
    logic [3:0] s;
    logic [1:0] w;
    logic       ill;
    ill = 1'b0;
    w = 2'd0;
    s = 4'hF;
    if (c == 2'd0) s = 4'h2;
    else if (c == 2'd1) s = 4'h6;
    else if (c == 2'd3) ill = v;
    else begin
      if (f == MFHI) w = 2'd1;
      if (f == MFLO) w = 2'd2;
      case (f)
        6'h20, 6'h21: s = 4'h2;
        6'h22, 6'h23: s = 4'h6;
        6'h24: s = 4'h0;
        6'h25: s = 4'h1;
        6'h27: s = 4'hC;
        6'h2A: s = 4'h7;
        6'h10, 6'h11, 6'h12, 6'h13, 6'h18, 6'h19, 6'h1A, 6'h1B: s = 4'h2;
        default: ill = v;
      endcase
    end
    return {ill, w, s};
  endfunction

  // Model state: cycles left until HI/LO update, committed and pending HI/LO
  int          m_cnt;
  logic [31:0] m_hi, m_lo, p_hi, p_lo;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt <= 0;
      m_hi  <= '0;
      m_lo  <= '0;
    end else if (m_cnt != 0) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) begin
        m_hi <= p_hi;
        m_lo <= p_lo;
      end
    end else if (bus.valid_in && bus.alu_class == 2'd2) begin
      case (bus.funct)
        MULT, MULTU, DIV, DIVU: begin
          {p_hi, p_lo} <= md_model(bus.funct, bus.rs_val, bus.rt_val);
          m_cnt <= XLEN + 1;
        end
        MTHI: m_hi <= bus.rs_val;
        6'h13: m_lo <= bus.rs_val;
        default: ;
      endcase
    end
  end

  // Every-cycle compare against the model
  always begin
    logic [6:0] e;
    logic       mdop;
    @(negedge clk);
    e = dec_model(bus.valid_in, bus.alu_class, bus.funct);
    mdop = bus.valid_in && bus.alu_class == 2'd2 &&
           (bus.funct inside {6'h10, 6'h11, 6'h12, 6'h13, 6'h18, 6'h19, 6'h1A, 6'h1B});
    chk("cmp alu_sel", bus.alu_sel, e[3:0]);
    chk("cmp wb_sel", bus.wb_sel, e[5:4]);
    chk("cmp illegal", bus.illegal, e[6]);
    chk("cmp busy", bus.busy, m_cnt != 0);
    chk("cmp md_done", bus.md_done, m_cnt == 1);
    chk("cmp stall", bus.stall, (m_cnt != 0) && mdop);
    chk("cmp hi_out", bus.hi_out, m_hi);
    chk("cmp lo_out", bus.lo_out, m_lo);
  end

  task automatic idle_in();
    bus.valid_in = 1'b0;
    bus.alu_class = 2'd0;
    bus.funct = 6'd0;
    bus.rs_val = '0;
    bus.rt_val = '0;
  endtask

  task automatic drive(input logic [1:0] c, input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    @(posedge clk);
    #1;
    bus.valid_in = 1'b1;
    bus.alu_class = c;
    bus.funct = f;
    bus.rs_val = a;
    bus.rt_val = b;
  endtask

  // Counts busy cycles after acceptance and the cycle md_done appears in; bounded
  task automatic wait_idle(output int busy_cyc, output int done_at);
    busy_cyc = 0;
    done_at = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!bus.busy) break;
      busy_cyc++;
      if (bus.md_done) done_at = busy_cyc;
    end
  endtask

  // Counts stall cycles of the held instruction; returns at the first non-stalled negedge
  task automatic wait_unstall(output int n);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!bus.stall) break;
      n++;
    end
  endtask

  task automatic run_md(input string name, input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eh, input logic [31:0] el);
    int bc, da;
    drive(2'd2, f, a, b);
    @(posedge clk);
    #1 idle_in();
    wait_idle(bc, da);
    chk({name, " busy cycles"}, bc, 33);
    chk({name, " md_done cycle"}, da, 33);
    chk({name, " hi"}, bus.hi_out, eh);
    chk({name, " lo"}, bus.lo_out, el);
  endtask

  typedef struct packed {
    logic [1:0] c;
    logic [5:0] f;
    logic [3:0] sel;
    logic       ill;
    logic [1:0] wb;
  } vec_t;

  vec_t vecs[14];

  initial begin
    int n, bc, da;
    vecs[0]  = '{2'd2, 6'h20, 4'h2, 1'b0, 2'd0};
    vecs[1]  = '{2'd2, 6'h21, 4'h2, 1'b0, 2'd0};
    vecs[2]  = '{2'd2, 6'h22, 4'h6, 1'b0, 2'd0};
    vecs[3]  = '{2'd2, 6'h23, 4'h6, 1'b0, 2'd0};
    vecs[4]  = '{2'd2, 6'h24, 4'h0, 1'b0, 2'd0};
    vecs[5]  = '{2'd2, 6'h25, 4'h1, 1'b0, 2'd0};
    vecs[6]  = '{2'd2, 6'h27, 4'hC, 1'b0, 2'd0};
    vecs[7]  = '{2'd2, 6'h2A, 4'h7, 1'b0, 2'd0};
    vecs[8]  = '{2'd2, 6'h07, 4'hF, 1'b1, 2'd0};
    vecs[9]  = '{2'd0, 6'h00, 4'h2, 1'b0, 2'd0};
    vecs[10] = '{2'd1, 6'h00, 4'h6, 1'b0, 2'd0};
    vecs[11] = '{2'd3, 6'h00, 4'hF, 1'b1, 2'd0};
    vecs[12] = '{2'd2, MFHI,  4'h2, 1'b0, 2'd1};
    vecs[13] = '{2'd2, MFLO,  4'h2, 1'b0, 2'd2};

    rst_n = 1'b0;
    idle_in();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset busy", bus.busy, 0);
    chk("reset md_done", bus.md_done, 0);
    chk("reset hi", bus.hi_out, 0);
    chk("reset lo", bus.lo_out, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Decode sweep
    foreach (vecs[i]) begin
      drive(vecs[i].c, vecs[i].f, 32'd0, 32'd0);
      @(negedge clk);
      chk("sweep alu_sel", bus.alu_sel, vecs[i].sel);
      chk("sweep illegal", bus.illegal, vecs[i].ill);
      chk("sweep wb_sel", bus.wb_sel, vecs[i].wb);
    end
    @(posedge clk);
    #1 idle_in();

    // Multiply / divide results and latency
    run_md("MULT", MULT, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    run_md("MULTU", MULTU, 32'hFFFF_FFFE, 32'd3, 32'h0000_0002, 32'hFFFF_FFFA);
    run_md("DIV -7/2", DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_md("DIV 5/0", DIV, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF);
    run_md("DIVU 5/0", DIVU, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF);
    run_md("DIV ovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);

    // DIVU arriving while MULTU runs is held and accepted in the first idle cycle
    drive(2'd2, MULTU, 32'd2, 32'd3);
    drive(2'd2, DIVU, 32'd100, 32'd7);
    wait_unstall(n);
    chk("held DIVU stall cycles", n, 33);
    chk("held DIVU first result lo", bus.lo_out, 32'd6);
    @(posedge clk);
    #1 idle_in();
    wait_idle(bc, da);
    chk("DIVU 100/7 busy cycles", bc, 33);
    chk("DIVU 100/7 lo", bus.lo_out, 32'd14);
    chk("DIVU 100/7 hi", bus.hi_out, 32'd2);

    // MFLO behind MULT, with a non-MD instruction in between
    drive(2'd2, MULT, 32'd7, 32'd6);
    drive(2'd2, 6'h20, 32'd1, 32'd2);
    @(negedge clk);
    chk("ADD during busy stall", bus.stall, 0);
    chk("ADD during busy busy", bus.busy, 1);
    drive(2'd2, MFLO, 32'd0, 32'd0);
    wait_unstall(n);
    chk("MFLO stall cycles", n, 32);
    chk("MFLO wb_sel", bus.wb_sel, 2);
    chk("MFLO lo", bus.lo_out, 32'd42);
    @(posedge clk);
    #1 idle_in();

    // MTHI in idle, then MTHI held behind a MULT
    drive(2'd2, MTHI, 32'h1234, 32'd0);
    @(posedge clk);
    #1 idle_in();
    @(negedge clk);
    chk("MTHI idle hi", bus.hi_out, 32'h1234);
    drive(2'd2, MULT, 32'd3, 32'd5);
    drive(2'd2, MTHI, 32'hDEAD, 32'd0);
    wait_unstall(n);
    chk("MTHI busy stall cycles", n, 33);
    chk("MTHI busy keeps MULT hi", bus.hi_out, 32'd0);
    chk("MTHI busy keeps MULT lo", bus.lo_out, 32'd15);
    @(posedge clk);
    #1 idle_in();
    @(negedge clk);
    chk("MTHI after release hi", bus.hi_out, 32'hDEAD);
    chk("MTHI after release lo", bus.lo_out, 32'd15);

    // Asynchronous reset in the middle of a run
    drive(2'd2, MULT, 32'h0001_2345, 32'h0000_0777);
    @(posedge clk);
    #1 idle_in();
    repeat (9) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("mid-run reset busy", bus.busy, 0);
    chk("mid-run reset md_done", bus.md_done, 0);
    chk("mid-run reset hi", bus.hi_out, 0);
    chk("mid-run reset lo", bus.lo_out, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    run_md("DIVU 9/3", DIVU, 32'd9, 32'd3, 32'd0, 32'd3);

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/alu_ctrl_md.md
Name: alu_ctrl_md

Overview:
- Parametrised next-generation ALU control for the MIPS core.
- Decodes the main-CU ALU class and the R-type funct field into a 4-bit ALU select for the single-cycle datapath.
- Adds an iterative HI/LO multiply/divide sequencer (MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI, MTLO) with a busy/stall handshake to the pipeline control.

Parameters:
- XLEN, 32: operand and HI/LO register width; must be even and at least 4.
- CNT_W, $clog2(XLEN)+1: iteration counter width. Derived localparam; not overridable.

Ports:
- clk  in  1  single system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- valid_in  in  1  instruction in decode is valid this cycle
- alu_class  in  2  from main CU: 00 = add (lw/sw/addi), 01 = sub (beq), 10 = R-type (use funct), 11 = reserved
- funct  in  6  instr[5:0]
- rs_val  in  XLEN  operand A / dividend / MTHI-MTLO source
- rt_val  in  XLEN  operand B / divisor
- alu_sel  out  4  0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1100 NOR, 1111 illegal
- wb_sel  out  2  writeback mux: 00 ALU, 01 HI, 10 LO
- illegal  out  1  unknown funct or alu_class = 11 while valid_in
- busy  out  1  sequencer running
- stall  out  1  pipeline must hold the decode stage
- hi_out  out  XLEN  HI register
- lo_out  out  XLEN  LO register
- md_done  out  1  one-cycle pulse when HI/LO are written by MULT/DIV

Behaviour:
- Reset (asynchronous, any state including mid-operation):
  - state = IDLE; busy = 0; md_done = 0; hi_out = lo_out = 0; counter = 0.
  - Any in-flight result is discarded.
- Decode is combinational and independent of state.
  - alu_class 00 → ADD; alu_class 01 → SUB.
  - alu_class 10 funct mapping: 100000/100001 → ADD; 100010/100011 → SUB; 100100 → AND; 100101 → OR; 100111 → NOR; 101010 → SLT.
  - wb_sel = 01 for MFHI (010000); wb_sel = 10 for MFLO (010010); wb_sel = 00 otherwise.
  - MD and MT functs drive alu_sel = 0010 (don't-care datapath).
  - Any other funct → alu_sel = 1111, illegal = 1.
- Let md_op = valid_in & alu_class == 10 & funct ∈ {011000..011011, 010000..010011}.
- stall = busy & md_op (combinational). Non-MD instructions never stall.
- State machine:
  - IDLE:
    - MULT/MULTU/DIV/DIVU accepted: latch magnitudes, result-sign flags and opcode; counter = 0; go to RUN.
    - MTHI writes hi_out = rs_val at the edge; MTLO writes lo_out = rs_val at the edge.
  - RUN: one radix-2 step per cycle. Multiply is shift-add; divide is restoring. counter++. When counter == XLEN-1, go to FIN.
  - FIN:
    - Apply sign correction. Signed multiply negates the 2·XLEN product if the operand signs differ. Signed divide: quotient sign = sign(a) xor sign(b); remainder sign = sign(a).
    - Write HI = upper/remainder and LO = lower/quotient.
    - md_done = 1 for this cycle; go to IDLE.
- busy = (state != IDLE).
- Latency: op accepted at edge 0; HI/LO visible after edge XLEN+1. An MFHI held by stall proceeds in the cycle after md_done.
- Divide by zero (rt_val = 0): still takes full latency; lo_out = all ones, hi_out = rs_val (signed and unsigned).
- Signed overflow (DIV most-negative / -1): lo_out = most-negative value, hi_out = 0; no trap.
- MD op arriving while busy: not accepted; it stalls and is accepted in the first IDLE cycle.
- MTHI/MTLO arriving while busy: stalls; does not corrupt the running result.
- Operands are sampled only at acceptance. Later rs_val/rt_val changes have no effect.

Decomposition:
- Shared package mips_alu_pkg:
  - alu_sel encodings (ALU_AND … ALU_ILL).
  - funct constants (F_ADD, F_MULT, F_MFHI, …).
  - alu_class encodings.
  - wb_sel encodings.
  - state enum {IDLE, RUN, FIN}.
- One natural sub-module: md_iter_core (XLEN). It holds the iterative multiply/divide datapath with start/op/done ports.
- The top level keeps the decode, stall logic and HI/LO registers.

Test Plan:
- Decode sweep: alu_class 10 with funct 100000, 100010, 100100, 100101, 100111, 101010 → alu_sel 0010, 0110, 0000, 0001, 1100, 0111; funct 000111 → 1111 with illegal = 1; alu_class 00 → 0010; alu_class 01 → 0110.
- MULT rs = 0xFFFFFFFE, rt = 3 → busy for 33 cycles, md_done at cycle 33, hi = 0xFFFFFFFF, lo = 0xFFFFFFFA; MULTU with the same operands → hi = 0x00000002, lo = 0xFFFFFFFA.
- DIVU 100/7 → lo = 14, hi = 2; DIV -7/2 → lo = 0xFFFFFFFD, hi = 0xFFFFFFFF; DIV 5/0 → lo = 0xFFFFFFFF, hi = 5.
- MFLO issued 1 cycle after MULT → stall high until md_done; MFLO proceeds the next cycle with wb_sel = 10 and the new lo; an interleaved ADD during busy → stall = 0.
- MTHI 0x1234 in IDLE → hi_out = 0x1234 next cycle; MTHI during busy → stall = 1 and the MULT result is not overwritten.
- rst_n low at RUN cycle 10 → busy, md_done, hi_out, lo_out = 0 immediately; after release, a new DIVU 9/3 → lo = 3, hi = 0.
